// File: rtl/pipe_stall_sequencer_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: state codes and
// the hazard-length normalisation helper.
package pipe_stall_sequencer_pkg;

    typedef enum logic {
        SEQ_RUN = 1'b0,
        SEQ_HZ  = 1'b1
    } seq_state_t;

    // A control-hazard request with length 0 still costs one bubble.
    localparam logic [1:0] LEN_NORM = 2'd1;

    function automatic logic [1:0] norm_len(input logic [1:0] len);
        return (len == 2'd0) ? LEN_NORM : len;
    endfunction

endpackage

// File: rtl/pipe_stall_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + CNT_ONE;
        end
    end

endmodule

// File: rtl/pipe_stall_sequencer.sv
// Central stall/flush scheduler for the 5-stage pipeline: arbitrates memory
// waits, data/control hazard bubbles and taken-branch flushes.
module pipe_stall_sequencer
    import pipe_stall_sequencer_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int MEM_TO = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data_haz_req,
    input  logic             ctrl_haz_req,
    input  logic [1:0]       ctrl_haz_len,
    input  logic             br_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             clr_cnt,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_we,
    output logic             mem_wb_bubble,
    output logic             busy,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TO) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TO - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    seq_state_t        state, state_nxt;
    logic [1:0]        remaining, remaining_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_stall;
    logic [1:0]        data_len, ctrl_len, req_len;

    always_comb begin
        mem_stall = dmem_req & ~dmem_ready;
        data_len  = data_haz_req ? 2'd1 : 2'd0;
        ctrl_len  = ctrl_haz_req ? norm_len(ctrl_haz_len) : 2'd0;
        req_len   = (ctrl_len > data_len) ? ctrl_len : data_len;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEQ_RUN;
            remaining <= 2'd0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
        end
    end

    // Mealy control: priority is memory wait, active hazard stall, new hazard,
    // taken branch, then normal flow.
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        pc_we         = 1'b1;
        if_id_we      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_we     = 1'b1;
        mem_wb_bubble = 1'b0;
        busy          = 1'b0;

        if (!rst_n) begin
            pc_we         = 1'b0;
            if_id_we      = 1'b0;
            ex_mem_we     = 1'b0;
            id_ex_bubble  = 1'b1;
            if_id_flush   = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (mem_stall) begin
            pc_we         = 1'b0;
            if_id_we      = 1'b0;
            ex_mem_we     = 1'b0;
            mem_wb_bubble = 1'b1;
            busy          = 1'b1;
        end else if (state == SEQ_HZ) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
            busy         = 1'b1;
            if (remaining <= 2'd1) begin
                state_nxt     = SEQ_RUN;
                remaining_nxt = 2'd0;
            end else begin
                remaining_nxt = remaining - 2'd1;
            end
        end else if (req_len != 2'd0) begin
            // A branch resolving now is dropped; it re-resolves after the bubble.
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
            busy         = 1'b1;
            if (req_len >= 2'd2) begin
                state_nxt     = SEQ_HZ;
                remaining_nxt = req_len - 2'd1;
            end
        end else if (br_taken) begin
            if_id_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            if (!mem_stall) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_LAST) begin
                wait_cnt <= wait_cnt + WAIT_ONE;
            end

            if (clr_cnt) begin
                mem_timeout <= 1'b0;
            end else if (mem_stall && (wait_cnt == WAIT_LAST)) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .inc   (id_ex_bubble),
        .q     (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .inc   (if_id_flush),
        .q     (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stall_sequencer.sv
// Directed bench for pipe_stall_sequencer with CNT_W=2 and MEM_TO=4.
module tb_pipe_stall_sequencer;

    localparam int CNT_W  = 2;
    localparam int MEM_TO = 4;

    // Bundle order: pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_bubble, busy
    localparam logic [6:0] O_IDLE  = 7'b1100100;
    localparam logic [6:0] O_BUB   = 7'b0001101;
    localparam logic [6:0] O_FLUSH = 7'b1110100;
    localparam logic [6:0] O_MEMW  = 7'b0000011;
    localparam logic [6:0] O_RST   = 7'b0011010;

    logic clk = 1'b0;
    logic rst_n;
    logic data_haz_req, ctrl_haz_req, br_taken, dmem_req, dmem_ready, clr_cnt;
    logic [1:0] ctrl_haz_len;
    logic pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_bubble, busy, mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    pipe_stall_sequencer #(.CNT_W(CNT_W), .MEM_TO(MEM_TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_haz_req  (data_haz_req),
        .ctrl_haz_req  (ctrl_haz_req),
        .ctrl_haz_len  (ctrl_haz_len),
        .br_taken      (br_taken),
        .dmem_req      (dmem_req),
        .dmem_ready    (dmem_ready),
        .clr_cnt       (clr_cnt),
        .pc_we         (pc_we),
        .if_id_we      (if_id_we),
        .if_id_flush   (if_id_flush),
        .id_ex_bubble  (id_ex_bubble),
        .ex_mem_we     (ex_mem_we),
        .mem_wb_bubble (mem_wb_bubble),
        .busy          (busy),
        .mem_timeout   (mem_timeout),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [6:0] exp);
        chk(tag, 32'({pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_bubble, busy}),
            32'(exp));
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled 2 units later.
    task automatic set_in(input logic d, input logic c, input logic [1:0] len, input logic br,
                          input logic req, input logic rdy, input logic clr);
        data_haz_req = d;
        ctrl_haz_req = c;
        ctrl_haz_len = len;
        br_taken     = br;
        dmem_req     = req;
        dmem_ready   = rdy;
        clr_cnt      = clr;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 2'd0, 0, 0, 0, 0);
        chk_out("reset_outputs", O_RST);
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("reset_flush_cnt", 32'(flush_cnt), 32'd0);
        chk("reset_timeout", 32'(mem_timeout), 32'd0);
        tick();
        set_in(1, 1, 2'd3, 1, 0, 0, 0);
        chk_out("reset_ignores_inputs", O_RST);
        tick();
        rst_n = 1'b1;
        set_in(0, 0, 2'd0, 0, 0, 0, 0);
        chk_out("idle_after_reset", O_IDLE);
        tick();

        // Load-use: one bubble
        set_in(1, 0, 2'd0, 0, 0, 0, 0);
        chk_out("loaduse_bubble", O_BUB);
        tick();
        set_in(0, 0, 2'd0, 0, 0, 0, 0);
        chk_out("loaduse_done", O_IDLE);
        chk("loaduse_stall_cnt", 32'(stall_cnt), 32'd1);
        set_in(0, 0, 2'd0, 0, 0, 0, 1);
        tick();

        // Control hazard len 3 with branch and data hazard in the same cycle
        set_in(1, 1, 2'd3, 1, 0, 0, 0);
        chk("ctrl_clr_cnt", 32'(stall_cnt), 32'd0);
        chk_out("ctrl_bub1", O_BUB);
        tick();
        set_in(1, 1, 2'd3, 1, 0, 0, 0);
        chk_out("ctrl_bub2_ignores_req", O_BUB);
        tick();
        set_in(0, 0, 2'd0, 0, 0, 0, 0);
        chk_out("ctrl_bub3", O_BUB);
        tick();
        set_in(0, 0, 2'd0, 0, 0, 0, 0);
        chk_out("ctrl_done", O_IDLE);
        chk("ctrl_stall_cnt", 32'(stall_cnt), 32'd3);
        chk("ctrl_flush_cnt", 32'(flush_cnt), 32'd0);
        set_in(0, 0, 2'd0, 0, 0, 0, 1);
        tick();

        // Length 0 normalises to a single bubble
        set_in(0, 1, 2'd0, 0, 0, 0, 0);
        chk_out("len0_bubble", O_BUB);
        tick();
        set_in(0, 0, 2'd0, 0, 0, 0, 0);
        chk_out("len0_done", O_IDLE);
        chk("len0_stall_cnt", 32'(stall_cnt), 32'd1);
        set_in(0, 0, 2'd0, 0, 0, 0, 1);
        tick();

        // Memory wait of 4 cycles starting in cycle 2 of a len-3 stall
        set_in(0, 1, 2'd3, 0, 0, 0, 0);
        chk_out("memhz_bub1", O_BUB);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 1, 2'd2, 1, 1, 0, 0);
            chk_out($sformatf("memhz_wait%0d", i), O_MEMW);
            chk($sformatf("memhz_stall_cnt%0d", i), 32'(stall_cnt), 32'd1);
            chk($sformatf("memhz_timeout%0d", i), 32'(mem_timeout), 32'd0);
            tick();
        end
        set_in(0, 0, 2'd0, 0, 1, 1, 0);
        chk_out("memhz_bub2", O_BUB);
        chk("memhz_timeout_set", 32'(mem_timeout), 32'd1);
        tick();
        set_in(0, 0, 2'd0, 0, 0, 0, 0);
        chk_out("memhz_bub3", O_BUB);
        tick();
        set_in(0, 0, 2'd0, 0, 0, 0, 0);
        chk_out("memhz_done", O_IDLE);
        chk("memhz_stall_cnt", 32'(stall_cnt), 32'd3);
        set_in(0, 0, 2'd0, 0, 0, 0, 1);
        tick();

        // Wait count restarts when the stall breaks: 3 + 3 cycles never times out
        for (int i = 0; i < 7; i++) begin
            set_in(0, 0, 2'd0, 0, 1, (i == 3), 0);
            chk($sformatf("split_timeout%0d", i), 32'(mem_timeout), 32'd0);
            tick();
        end
        set_in(0, 0, 2'd0, 0, 0, 0, 0);
        chk("split_timeout_end", 32'(mem_timeout), 32'd0);
        tick();

        // Wait held 6 cycles: timeout rises after the 4th, survives dmem_ready
        for (int i = 0; i < 6; i++) begin
            set_in(0, 0, 2'd0, 0, 1, 0, 0);
            chk($sformatf("to_wait%0d", i), 32'(mem_timeout), (i >= 4) ? 32'd1 : 32'd0);
            tick();
        end
        set_in(0, 0, 2'd0, 0, 1, 1, 0);
        chk_out("to_ready_idle", O_IDLE);
        chk("to_sticky", 32'(mem_timeout), 32'd1);
        tick();
        set_in(0, 0, 2'd0, 0, 0, 0, 1);
        tick();
        set_in(0, 0, 2'd0, 0, 0, 0, 0);
        chk("to_cleared", 32'(mem_timeout), 32'd0);
        chk("to_clr_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("to_clr_flush_cnt", 32'(flush_cnt), 32'd0);
        tick();

        // Memory stall in RUN masks hazards and branches
        set_in(1, 1, 2'd3, 1, 1, 0, 0);
        chk_out("memrun_masks", O_MEMW);
        tick();
        set_in(0, 0, 2'd0, 0, 0, 0, 0);
        chk_out("memrun_after", O_IDLE);
        chk("memrun_flush_cnt", 32'(flush_cnt), 32'd0);
        chk("memrun_stall_cnt", 32'(stall_cnt), 32'd0);
        tick();

        // Saturation of flush_cnt at 3
        for (int i = 0; i < 5; i++) begin
            set_in(0, 0, 2'd0, 1, 0, 0, 0);
            chk_out($sformatf("sat_flush%0d", i), O_FLUSH);
            chk($sformatf("sat_cnt%0d", i), 32'(flush_cnt), (i >= 3) ? 32'd3 : 32'(i));
            tick();
        end
        set_in(0, 0, 2'd0, 0, 0, 0, 0);
        chk("sat_hold", 32'(flush_cnt), 32'd3);
        tick();
        set_in(0, 0, 2'd0, 1, 0, 0, 1);
        chk_out("sat_clr_flush", O_FLUSH);
        tick();
        set_in(0, 0, 2'd0, 0, 0, 0, 0);
        chk("sat_clr_wins", 32'(flush_cnt), 32'd0);
        tick();

        // Reset in the middle of a hazard stall
        set_in(0, 1, 2'd3, 0, 0, 0, 0);
        chk_out("midrst_bub1", O_BUB);
        tick();
        set_in(0, 0, 2'd0, 0, 0, 0, 0);
        chk_out("midrst_bub2", O_BUB);
        rst_n = 1'b0;
        #1;
        chk_out("midrst_forced", O_RST);
        chk("midrst_stall_cnt", 32'(stall_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        set_in(0, 0, 2'd0, 0, 0, 0, 0);
        chk_out("midrst_idle", O_IDLE);
        tick();
        set_in(0, 0, 2'd0, 0, 0, 0, 0);
        chk_out("midrst_idle2", O_IDLE);
        chk("midrst_cnt_after", 32'(stall_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
